// File: rtl/ft245_pkg.sv
// Shared definitions for the FT245 bus reader and writer: sequencing states,
// default strobe timing and the timer width.
package ft245_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RECOVER = 2'd2
  } ft_state_t;

  localparam int RD_LOW_CYCLES_DEF  = 2;
  localparam int RD_HIGH_CYCLES_DEF = 3;
  localparam int CNT_W              = 4;

endpackage

// File: rtl/ft245_rx_byte_fifo.sv
// First-word-fall-through byte FIFO: head byte is always on dout while valid.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  push,
  input  logic [7:0]            din,
  input  logic                  pop,
  output logic [7:0]            dout,
  output logic                  valid,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign valid   = (level != '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && valid;
  assign do_push = push && ((level != FULL_LEVEL) || do_pop);

  always_ff @(posedge clk) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; contents are only observable behind valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ft245_rx.sv
// FT245 receive controller: synchronizes RXF#, paces RD# strobes and buffers
// captured bytes in a FWFT FIFO with a valid/ready output.
//
// state   | meaning
// IDLE    | rd high, waiting for rxf_s low and room in the FIFO
// STROBE  | rd low for RD_LOW_CYCLES, byte captured on the last edge
// RECOVER | rd high for RD_HIGH_CYCLES so a stale RXF# is not re-read
module ft245_rx
  import ft245_pkg::*;
#(
  parameter int RD_LOW_CYCLES  = RD_LOW_CYCLES_DEF,
  parameter int RD_HIGH_CYCLES = RD_HIGH_CYCLES_DEF,
  parameter int DEPTH_LOG2     = 4
) (
  input  logic                clk,
  input  logic                reset_in,
  input  logic                rxf,
  input  logic [7:0]          data_in,
  output logic                rd,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DEPTH_LOG2:0] level
);

  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [CNT_W-1:0]    LOW_LOAD   = CNT_W'(RD_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]    HIGH_LOAD  = CNT_W'(RD_HIGH_CYCLES - 1);

  logic             rxf_m;
  logic             rxf_s;
  ft_state_t        state;
  ft_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rd_nxt;
  logic             push;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      rxf_m <= 1'b1;
      rxf_s <= 1'b1;
    end else begin
      rxf_m <= rxf;
      rxf_s <= rxf_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state <= IDLE;
      cnt   <= '0;
      rd    <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rd    <= rd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = rd;
    push      = 1'b0;
    case (state)
      IDLE: begin
        // Room is reserved here; pops during the strobe can only add space.
        if (!rxf_s && (level != FULL_LEVEL)) begin
          rd_nxt    = 1'b0;
          cnt_nxt   = LOW_LOAD;
          state_nxt = STROBE;
        end else begin
          rd_nxt = 1'b1;
        end
      end
      STROBE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          push      = 1'b1;
          rd_nxt    = 1'b1;
          cnt_nxt   = HIGH_LOAD;
          state_nxt = RECOVER;
        end
      end
      RECOVER: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        rd_nxt    = 1'b1;
      end
    endcase
  end

  byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset_in (reset_in),
    .push     (push),
    .din      (data_in),
    .pop      (out_ready),
    .dout     (out_data),
    .valid    (out_valid),
    .level    (level)
  );

endmodule

// File: tb/tb_ft245_rx.sv
// Bench for ft245_rx: a queue-based FT245 chip and FIFO model drive and check
// the DUT cycle by cycle through directed and randomized scenarios.
module tb_ft245_rx;

  localparam int RD_LOW     = 2;
  localparam int RD_HIGH    = 3;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int PERIOD     = RD_LOW + RD_HIGH + 1;

  logic                clk = 1'b0;
  logic                reset_in;
  logic                rxf;
  logic [7:0]          data_in;
  logic                rd;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;
  logic [DEPTH_LOG2:0] level;

  always #5 clk = ~clk;

  ft245_rx #(
    .RD_LOW_CYCLES (RD_LOW),
    .RD_HIGH_CYCLES(RD_HIGH),
    .DEPTH_LOG2    (DEPTH_LOG2)
  ) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .rxf      (rxf),
    .data_in  (data_in),
    .rd       (rd),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] chip_q[$];   // bytes waiting inside the FT245
  logic [7:0] exp_q[$];    // bytes the DUT FIFO should hold, head first
  int   cyc = 0;
  int   last_fall = -1;
  int   low_cnt = 0;
  int   falls = 0;
  int   strobes = 0;
  int   pops = 0;
  logic prev_rd = 1'b1;
  bit   check_period = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_chip();
    rxf     = (chip_q.size() == 0);
    data_in = (chip_q.size() != 0) ? chip_q[0] : 8'($urandom);
  endtask

  task automatic step();
    logic       pop_now;
    logic [7:0] bus;
    logic [7:0] tmp;
    pop_now = out_valid && out_ready;
    bus     = data_in;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_now && exp_q.size() != 0) begin
      tmp = exp_q.pop_front();
      pops++;
    end
    if (prev_rd && !rd) begin
      if (check_period && last_fall >= 0) chk("rd_period", cyc - last_fall, PERIOD);
      last_fall = cyc;
      falls++;
      low_cnt = 0;
    end
    if (!rd) low_cnt++;
    if (!prev_rd && rd) begin
      chk("rd_low_width", low_cnt, RD_LOW);
      exp_q.push_back(bus);
      if (chip_q.size() != 0) tmp = chip_q.pop_front();
      strobes++;
    end
    prev_rd = rd;
    drive_chip();
    chk("level", level, exp_q.size());
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
  endtask

  task automatic do_reset(input int n);
    reset_in  = 1'b1;
    out_ready = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    exp_q.delete();
    prev_rd = 1'b1;
    low_cnt = 0;
    chk("rst_rd", rd, 1);
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    reset_in = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget, input string tag);
    int n = 0;
    while (strobes < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, strobes, target);
  endtask

  task automatic wait_falls(input int target, input int budget, input string tag);
    int n = 0;
    while (falls < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, falls, target);
  endtask

  initial begin
    int t0, s0, p0, n;
    logic [7:0] nxt;

    reset_in  = 1'b1;
    rxf       = 1'b1;
    data_in   = 8'h00;
    out_ready = 1'b0;
    do_reset(3);

    // Single byte
    chip_q.push_back(8'hA5);
    drive_chip();
    t0 = cyc;
    wait_falls(falls + 1, 20, "single_fall");
    chk("first_fall_latency", last_fall - t0, 3);
    wait_strobes(1, 20, "single_strobe");
    chk("single_data", out_data, 8'hA5);
    chk("single_valid", out_valid, 1);
    chk("single_level", level, 1);
    repeat (10) step();
    chk("single_no_extra", strobes, 1);

    // Stream with consumer always ready
    check_period = 1'b1;
    last_fall    = -1;
    out_ready    = 1'b1;
    for (int i = 0; i < 16; i++) chip_q.push_back(8'(i));
    drive_chip();
    s0 = strobes;
    p0 = pops;
    wait_strobes(s0 + 16, 200, "stream_strobes");
    repeat (5) step();
    chk("stream_pops", pops - p0, 17);
    check_period = 1'b0;

    // Full: 20 offered, 16 taken, then one pop lets exactly one more in
    out_ready = 1'b0;
    s0 = strobes;
    for (int i = 0; i < 20; i++) chip_q.push_back(8'($urandom));
    drive_chip();
    repeat (200) step();
    chk("full_strobes", strobes - s0, DEPTH);
    chk("full_level", level, DEPTH);
    chk("full_rd_high", rd, 1);
    chk("full_chip_left", chip_q.size(), 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (40) step();
    chk("full_one_more", strobes - s0, DEPTH + 1);
    chk("full_level_again", level, DEPTH);

    // Simultaneous push and pop at level 5
    do_reset(2);
    chip_q.delete();
    for (int i = 0; i < 5; i++) chip_q.push_back(8'($urandom));
    drive_chip();
    s0 = strobes;
    wait_strobes(s0 + 5, 100, "pp_fill");
    repeat (4) step();
    chk("pp_level_before", level, 5);
    chip_q.push_back(8'($urandom));
    drive_chip();
    n = 0;
    while (!(!rd && low_cnt == RD_LOW) && n < 30) begin
      step();
      n++;
    end
    chk("pp_reach_push_edge", (!rd && low_cnt == RD_LOW), 1);
    nxt = exp_q[1];
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_level", level, 5);
    chk("pp_data", out_data, nxt);

    // Reset while RD# is low
    chip_q.push_back(8'($urandom));
    drive_chip();
    n = 0;
    while (rd && n < 30) begin
      step();
      n++;
    end
    chk("mid_rd_low", rd, 0);
    do_reset(1);
    t0 = cyc;
    s0 = strobes;
    wait_strobes(s0 + 1, 30, "mid_restrobe");
    chk("mid_refall_latency", last_fall - t0, 3);
    chk("mid_level", level, 1);

    // Pointer wrap with random backpressure
    do_reset(2);
    chip_q.delete();
    for (int i = 0; i < 40; i++) chip_q.push_back(8'($urandom));
    drive_chip();
    s0 = strobes;
    p0 = pops;
    n  = 0;
    while ((strobes - s0 < 40 || exp_q.size() != 0) && n < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("wrap_strobes", strobes - s0, 40);
    chk("wrap_pops", pops - p0, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
